// File: rtl/sensor_offset_calibrator.sv
// Sensor offset calibration: settle, windowed per-channel averaging, range check.
// Latches per-channel averages as offsets when every channel is within limit.
module sensor_offset_calibrator #(
    parameter int NCH        = 6,
    parameter int W          = 16,
    parameter int LOG2_DEPTH = 6,
    parameter bit SIGNED     = 1'b1,
    parameter int SETTLE_SEC = 1,
    parameter int ACQ_SEC    = 3
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic             abort,
    input  logic             en_sec,
    output logic             reset_sec,
    output logic             sensor_start,
    input  logic             sample_valid,
    input  logic [NCH*W-1:0] sample_data,
    input  logic [W-1:0]     limit_abs,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [1:0]       error_code,
    output logic [NCH-1:0]   error_mask,
    output logic [NCH*W-1:0] offset
);

    localparam int DEPTH = 1 << LOG2_DEPTH;
    localparam int SW    = W + LOG2_DEPTH;

    typedef enum logic [2:0] {
        IDLE, SETTLE, ACQUIRE, EVALUATE, PASS, FAIL
    } state_t;

    state_t                state, state_nx;
    logic [3:0]            timer;
    logic [LOG2_DEPTH:0]   fill;
    logic [LOG2_DEPTH-1:0] widx;
    logic [SW-1:0]         sum  [NCH];
    logic [W-1:0]          ring [NCH][DEPTH];

    logic                  full;
    logic                  acq_wr;
    logic                  settle_entry;
    logic [NCH-1:0]        ch_fail;
    logic [NCH*W-1:0]      avg_all;

    function automatic logic [SW-1:0] ext(input logic [W-1:0] v);
        if (SIGNED)
            return {{LOG2_DEPTH{v[W-1]}}, v};
        return {{LOG2_DEPTH{1'b0}}, v};
    endfunction

    assign full = (fill == (LOG2_DEPTH+1)'(DEPTH));

    // Top W bits of the sum give the floor-divided average in both encodings
    always_comb begin
        logic [W-1:0] avg;
        logic [W:0]   mag;
        avg     = '0;
        mag     = '0;
        avg_all = '0;
        ch_fail = '0;
        for (int k = 0; k < NCH; k++) begin
            avg = sum[k][SW-1 -: W];
            avg_all[k*W +: W] = avg;
            if (SIGNED && avg[W-1])
                mag = {1'b0, ~avg} + (W+1)'(1);
            else
                mag = {1'b0, avg};
            ch_fail[k] = (mag > {1'b0, limit_abs});
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:     if (start) state_nx = SETTLE;
            SETTLE:   if (timer == 4'(SETTLE_SEC)) state_nx = ACQUIRE;
            ACQUIRE:  if (timer == 4'(ACQ_SEC)) state_nx = EVALUATE;
            EVALUATE: state_nx = (full && ch_fail == '0) ? PASS : FAIL;
            PASS,
            FAIL:     if (start) state_nx = SETTLE;
            default:  state_nx = IDLE;
        endcase
        if (abort)
            state_nx = IDLE;
    end

    assign reset_sec    = (state_nx != state);
    assign busy         = (state == SETTLE) || (state == ACQUIRE)
                       || (state == EVALUATE);
    assign sensor_start = busy;
    assign done         = (state == PASS);
    assign error        = (state == FAIL);

    assign settle_entry = (state_nx == SETTLE) && (state != SETTLE);
    // The ACQUIRE exit cycle must not accept a sample
    assign acq_wr       = (state == ACQUIRE) && (state_nx == ACQUIRE)
                       && sample_valid;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            timer      <= '0;
            fill       <= '0;
            widx       <= '0;
            offset     <= '0;
            error_code <= '0;
            error_mask <= '0;
            for (int k = 0; k < NCH; k++)
                sum[k] <= '0;
        end else begin
            state <= state_nx;
            if (state_nx != state)
                timer <= '0;
            else if (en_sec && timer != 4'hF)
                timer <= timer + 4'd1;

            if (settle_entry) begin
                fill       <= '0;
                widx       <= '0;
                error_code <= '0;
                error_mask <= '0;
                for (int k = 0; k < NCH; k++)
                    sum[k] <= '0;
            end else if (acq_wr) begin
                for (int k = 0; k < NCH; k++)
                    sum[k] <= sum[k] + ext(sample_data[k*W +: W])
                            - (full ? ext(ring[k][widx]) : '0);
                widx <= widx + 1'b1;
                if (!full)
                    fill <= fill + 1'b1;
            end

            if (state == EVALUATE && !abort) begin
                if (!full) begin
                    error_code <= 2'd1;
                    error_mask <= '1;
                end else begin
                    error_mask <= ch_fail;
                    if (|ch_fail)
                        error_code <= 2'd2;
                    else
                        offset <= avg_all;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (acq_wr)
            for (int k = 0; k < NCH; k++)
                ring[k][widx] <= sample_data[k*W +: W];
    end

endmodule

// File: tb/tb_sensor_offset_calibrator.sv
// Bench for sensor_offset_calibrator: table-driven runs with a result
// scoreboard, plus abort and reset interrupt sequences.
module tb_sensor_offset_calibrator;

    logic         clock = 1'b0;
    logic         reset_n = 1'b0;
    logic         start = 1'b0;
    logic         abort = 1'b0;
    logic         en_sec = 1'b0;
    logic         sample_valid = 1'b0;
    logic [95:0]  sample_data = '0;
    logic [15:0]  limit_abs = 16'd4500;
    logic         reset_sec;
    logic         sensor_start;
    logic         busy;
    logic         done;
    logic         error;
    logic [1:0]   error_code;
    logic [5:0]   error_mask;
    logic [95:0]  offset;

    sensor_offset_calibrator dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .start        (start),
        .abort        (abort),
        .en_sec       (en_sec),
        .reset_sec    (reset_sec),
        .sensor_start (sensor_start),
        .sample_valid (sample_valid),
        .sample_data  (sample_data),
        .limit_abs    (limit_abs),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .error_code   (error_code),
        .error_mask   (error_mask),
        .offset       (offset)
    );

    always #5 clock = ~clock;

    typedef struct {
        int          mode;
        logic [95:0] vals;
        int          nsamp;
        logic [15:0] limit;
        logic        pass;
        logic [1:0]  code;
        logic [5:0]  mask;
        logic [95:0] off;
    } vec_t;

    typedef struct {
        logic        pass;
        logic [1:0]  code;
        logic [5:0]  mask;
        logic [95:0] off;
    } exp_t;

    exp_t        sb[$];
    vec_t        tbl[9];
    logic [95:0] last_off = '0;
    logic [95:0] junk = {6{16'h7777}};
    int          n_run = 0;
    int          n_fail = 0;

    task automatic chk(input string name, input logic [95:0] act,
                       input logic [95:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [95:0] rep(input logic [15:0] v);
        return {6{v}};
    endfunction

    function automatic logic [95:0] gen(input int mode,
                                        input logic [95:0] vals,
                                        input int i);
        case (mode)
            1:       return {80'd0, (i % 2 == 0) ? 16'hFFFD : 16'hFFFC};
            2:       return rep(16'(i));
            default: return vals;
        endcase
    endfunction

    task automatic tick();
        en_sec = 1'b1;
        @(negedge clock);
        en_sec = 1'b0;
    endtask

    task automatic outs_idle(input string name);
        chk(name, {busy, sensor_start, done, error}, 4'b0000);
    endtask

    task automatic run_vec(input vec_t v);
        exp_t e;
        int   c;
        limit_abs = v.limit;
        e.pass = v.pass;
        e.code = v.code;
        e.mask = v.mask;
        e.off  = v.pass ? v.off : last_off;
        if (v.pass)
            last_off = v.off;
        sb.push_back(e);

        start = 1'b1;
        sample_valid = 1'b1;
        sample_data = junk;
        @(negedge clock);
        start = 1'b0;
        chk("settle_outs", {busy, sensor_start, done, error}, 4'b1100);
        @(negedge clock);
        tick();
        chk("settle_exit_reset_sec", reset_sec, 1'b1);
        @(negedge clock);
        chk("acq_steady_reset_sec", reset_sec, 1'b0);

        for (int i = 0; i < v.nsamp; i++) begin
            sample_data = gen(v.mode, v.vals, i);
            @(negedge clock);
        end
        sample_valid = 1'b0;
        for (int t = 0; t < 3; t++) begin
            @(negedge clock);
            tick();
        end
        // Junk offered in the exit cycle and during EVALUATE
        sample_valid = 1'b1;
        sample_data = junk;
        chk("acq_exit_reset_sec", reset_sec, 1'b1);
        c = 0;
        while (c < 20 && !(done || error)) begin
            @(negedge clock);
            c++;
        end
        sample_valid = 1'b0;

        if (sb.size() == 0) begin
            chk("scoreboard_empty", 1'b1, 1'b0);
        end else begin
            e = sb.pop_front();
            chk("eval_latency", 96'(c), 96'd2);
            chk("done", done, e.pass);
            chk("error", error, !e.pass);
            chk("error_code", error_code, e.code);
            chk("error_mask", error_mask, e.mask);
            chk("offset", offset, e.off);
        end
    endtask

    initial begin
        tbl[0] = '{0, rep(16'd100), 70, 16'd4500, 1'b1, 2'd0, 6'h00,
                   rep(16'd100)};
        tbl[1] = '{1, 96'd0, 66, 16'd4500, 1'b1, 2'd0, 6'h00,
                   {80'd0, 16'hFFFC}};
        tbl[2] = '{0, rep(16'd100), 40, 16'd4500, 1'b0, 2'd1, 6'h3F, '0};
        tbl[3] = '{0, {48'd0, 16'd5000, 32'd0}, 64, 16'd4500, 1'b0, 2'd2,
                   6'h04, '0};
        tbl[4] = '{2, 96'd0, 200, 16'd4500, 1'b1, 2'd0, 6'h00,
                   rep(16'd167)};
        tbl[5] = '{0, {16'hEC78, {5{16'd7}}}, 64, 16'd4500, 1'b0, 2'd2,
                   6'h20, '0};
        tbl[6] = '{0, {{4{16'd4500}}, 16'hEE6C, 16'd4500}, 64, 16'd4500,
                   1'b1, 2'd0, 6'h00,
                   {{4{16'd4500}}, 16'hEE6C, 16'd4500}};
        tbl[7] = '{0, {32'd0, 16'd4501, 48'd0}, 64, 16'd4500, 1'b0, 2'd2,
                   6'h08, '0};
        tbl[8] = '{0, rep(16'd1), 63, 16'd4500, 1'b0, 2'd1, 6'h3F, '0};

        repeat (2) @(negedge clock);
        outs_idle("reset_outs");
        chk("reset_regs", {error_code, error_mask, offset}, '0);
        reset_n = 1'b1;
        @(negedge clock);

        foreach (tbl[i])
            run_vec(tbl[i]);

        // FAIL holds its code and mask while ticks keep arriving
        repeat (3) begin
            @(negedge clock);
            tick();
        end
        chk("fail_hold", {error, error_code, error_mask}, {1'b1, 2'd1, 6'h3F});

        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        outs_idle("abort_from_fail");
        chk("abort_keeps_offset", offset, last_off);

        // abort together with start in the middle of ACQUIRE
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        @(negedge clock);
        tick();
        @(negedge clock);
        sample_valid = 1'b1;
        sample_data = rep(16'd9);
        repeat (5) @(negedge clock);
        chk("acq_busy", {busy, sensor_start}, 2'b11);
        abort = 1'b1;
        start = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        start = 1'b0;
        sample_valid = 1'b0;
        outs_idle("abort_start_idle");
        repeat (3) @(negedge clock);
        tick();
        outs_idle("abort_stays_idle");
        chk("abort_acq_offset", offset, last_off);

        // asynchronous reset in the middle of SETTLE
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        chk("settle_before_reset", busy, 1'b1);
        #2 reset_n = 1'b0;
        #1;
        outs_idle("async_reset_outs");
        chk("async_reset_regs", {reset_sec, error_code, error_mask, offset}, '0);
        @(negedge clock);
        reset_n = 1'b1;
        last_off = '0;
        tick();
        repeat (3) @(negedge clock);
        outs_idle("no_resume_after_reset");

        run_vec(tbl[0]);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
